// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared definitions for the APB register slave: the transfer
//                FSM state encoding, the upper bound on inserted wait states
//                and the width of the wait-state counter that follows from it.
//  Contents    : apb_state_e      - IDLE / SETUP / ACCESS
//                MAX_WAIT_STATES  - largest legal WAIT_STATES value
//                WAIT_CNT_W       - bits needed to hold 0..MAX_WAIT_STATES
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

   localparam int MAX_WAIT_STATES = 15;
   localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_bank
//  Description : Register storage behind the APB slave. Holds NUM_REGS
//                registers of DATA_W bits, decodes the committed write,
//                raises a one-cycle strobe for the written register and
//                provides the read mux for the read-data cycle.
//  Ports       : clk_i      - clock, rising edge
//                reset_n    - asynchronous active-low reset
//                commit     - write commit pulse (pready cycle of a write)
//                rd_en      - read data enable (pready cycle of a read)
//                addr       - latched register index
//                wdata      - latched write data
//                prdata     - read data, zero unless rd_en and addr in range
//                reg_q_o    - all registers, reg i at [i*DATA_W +: DATA_W]
//                wr_strb_o  - one-cycle pulse per register written
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_bank #(
   parameter int                ADDR_W   = 3,
   parameter int                DATA_W   = 8,
   parameter int                NUM_REGS = 8,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                       clk_i,
   input  logic                       reset_n,
   input  logic                       commit,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          prdata,
   output logic [NUM_REGS*DATA_W-1:0] reg_q_o,
   output logic [NUM_REGS-1:0]        wr_strb_o
);

   // One-hot register select; all zero when the index is outside the bank,
   // which discards out-of-range writes and zeroes out-of-range reads.
   logic [NUM_REGS-1:0] sel;
   logic [DATA_W-1:0]   rd_mux;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic [DATA_W-1:0] q;

      assign sel[i] = (addr == ADDR_W'(i));

      always_ff @(posedge clk_i or negedge reset_n) begin
         if (!reset_n) begin
            q <= RST_VAL;
         end else if (commit && sel[i]) begin
            q <= wdata;
         end
      end

      assign reg_q_o[i*DATA_W +: DATA_W] = q;
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         wr_strb_o <= '0;
      end else begin
         wr_strb_o <= commit ? sel : '0;
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel[i]) begin
            rd_mux = reg_q_o[i*DATA_W +: DATA_W];
         end
      end
   end

   assign prdata = rd_en ? rd_mux : '0;

endmodule : apb_reg_bank
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_reg_slave
//  Description : APB slave fronting a bank of NUM_REGS registers. A three-state
//                FSM (IDLE/SETUP/ACCESS) follows the bus one cycle behind:
//                the setup phase is latched while in IDLE, SETUP waits for
//                penable, and ACCESS runs a wait counter loaded with
//                WAIT_STATES; pready is registered and high only in the ACCESS
//                cycle whose counter is zero. Writes commit on the edge that
//                ends the pready cycle.
//  Config      : APB_REG_SLAVE_PSLVERR_EN - when defined, pslverr is raised
//                together with pready for an out-of-range index; otherwise
//                pslverr is tied low.
//  Ports       : clk_i     - clock, rising edge
//                reset_n   - asynchronous active-low reset
//                psel, penable, pwrite, paddr, pwdata - APB requester side
//                prdata, pready, pslverr               - APB completer side
//                reg_q_o   - all register contents
//                wr_strb_o - one-cycle pulse per register written
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int                ADDR_W      = 3,
   parameter int                DATA_W      = 8,
   parameter int                NUM_REGS    = 8,
   parameter int                WAIT_STATES = 0,
   parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
   input  logic                       clk_i,
   input  logic                       reset_n,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic [DATA_W-1:0]          pwdata,
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic [NUM_REGS*DATA_W-1:0] reg_q_o,
   output logic [NUM_REGS-1:0]        wr_strb_o
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_STATES);

   apb_state_e            state, state_nxt;
   logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
   logic                  pready_nxt;
   logic                  latch;

   // Transfer attributes captured in the setup phase; later bus changes are
   // ignored until the next setup phase.
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic                  write_q;

   logic                  commit;
   logic                  rd_en;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         pready  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         pready <= pready_nxt;
         if (latch) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      pready_nxt = 1'b0;
      latch      = 1'b0;
      unique case (state)
         IDLE: begin
            // penable without a preceding setup phase is ignored here.
            if (psel && !penable) begin
               state_nxt = SETUP;
               latch     = 1'b1;
            end
         end
         SETUP: begin
            if (!psel) begin
               state_nxt = IDLE;
            end else if (penable) begin
               state_nxt  = ACCESS;
               cnt_nxt    = WAIT_LD;
               pready_nxt = (WAIT_LD == '0);
            end
         end
         ACCESS: begin
            if (pready) begin
               // Completion cycle: a new setup phase already on the bus
               // chains straight into SETUP without passing through IDLE.
               cnt_nxt = '0;
               if (psel && !penable) begin
                  state_nxt = SETUP;
                  latch     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (!psel) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               // pready is registered, so it is requested one cycle ahead,
               // when the counter is about to reach zero.
               cnt_nxt    = cnt - 1'b1;
               pready_nxt = (cnt == WAIT_CNT_W'(1));
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign commit = pready &  write_q;
   assign rd_en  = pready & ~write_q;

`ifdef APB_REG_SLAVE_PSLVERR_EN
   localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
   logic addr_ok;
   assign addr_ok = ({1'b0, addr_q} < NUM_REGS_C);
   assign pslverr = pready & ~addr_ok;
`else
   assign pslverr = 1'b0;
`endif

   apb_reg_bank #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RST_VAL  (RST_VAL)
   ) u_bank (
      .clk_i     (clk_i),
      .reset_n   (reset_n),
      .commit    (commit),
      .rd_en     (rd_en),
      .addr      (addr_q),
      .wdata     (wdata_q),
      .prdata    (prdata),
      .reg_q_o   (reg_q_o),
      .wr_strb_o (wr_strb_o)
   );

endmodule : apb_reg_slave
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_reg_slave
//  Description : Directed self-checking bench for apb_reg_slave. Three
//                instances share the bus data lines and have private psel:
//                  0 - defaults (WAIT_STATES=0, NUM_REGS=8)
//                  1 - WAIT_STATES=3
//                  2 - NUM_REGS=6, WAIT_STATES=2, RST_VAL=8'h5A
//                Inputs change 1 time unit after the rising edge and outputs
//                are sampled there too.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

`ifdef APB_REG_SLAVE_PSLVERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        psel    [3];
   logic        penable;
   logic        pwrite;
   logic [2:0]  paddr;
   logic [7:0]  pwdata;
   logic [7:0]  prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];
   logic [63:0] reg_q0, reg_q1;
   logic [47:0] reg_q2;
   logic [7:0]  strb0, strb1;
   logic [5:0]  strb2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_reg_slave u_w0 (
      .clk_i(clk), .reset_n(reset_n), .psel(psel[0]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]),
      .pready(pready[0]), .pslverr(pslverr[0]), .reg_q_o(reg_q0), .wr_strb_o(strb0)
   );

   apb_reg_slave #(.WAIT_STATES(3)) u_w3 (
      .clk_i(clk), .reset_n(reset_n), .psel(psel[1]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]),
      .pready(pready[1]), .pslverr(pslverr[1]), .reg_q_o(reg_q1), .wr_strb_o(strb1)
   );

   apb_reg_slave #(.NUM_REGS(6), .WAIT_STATES(2), .RST_VAL(8'h5A)) u_n6 (
      .clk_i(clk), .reset_n(reset_n), .psel(psel[2]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]),
      .pready(pready[2]), .pslverr(pslverr[2]), .reg_q_o(reg_q2), .wr_strb_o(strb2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full transfer on instance s. Returns the cycle count from the setup
   // cycle to pready, prdata/pslverr in the pready cycle, and the OR of prdata
   // over all earlier cycles. Returns in the pready cycle with psel dropped.
   task automatic xfer(input int s, input logic wr, input logic [2:0] a,
                       input logic [7:0] d, output int lat, output logic [7:0] rd,
                       output logic err, output logic [7:0] stray);
      stray   = '0;
      psel[s] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      lat     = 0;
      stray   |= prdata[s];
      tick;
      lat     = 1;
      penable = 1'b1;
      paddr   = ~a;
      pwdata  = ~d;
      while (lat < 40) begin
         tick;
         lat++;
         if (pready[s]) break;
         stray |= prdata[s];
      end
      rd      = prdata[s];
      err     = pslverr[s];
      psel[s] = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      int         lat;
      logic [7:0] rd;
      logic [7:0] stray;
      logic       err;
      logic       any_rdy;
      logic [5:0] any_strb;

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) psel[i] = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (2) tick;
      check("rst_pready0",  64'(pready[0]), 64'(0));
      check("rst_prdata2",  64'(prdata[2]), 64'(0));
      check("rst_pslverr2", 64'(pslverr[2]), 64'(0));
      check("rst_strb0",    64'(strb0), 64'(0));
      check("rst_regs0",    reg_q0, 64'(0));
      check("rst_regs2",    64'(reg_q2), 64'h5A5A_5A5A_5A5A);
      reset_n = 1'b1;
      tick;

      // ---------------- write A5 to addr 2, WAIT_STATES=0 ----------------
      psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'hA5;
      tick;
      check("w0_setup_pready", 64'(pready[0]), 64'(0));
      penable = 1'b1; paddr = 3'd5; pwdata = 8'hFF;
      tick;
      check("w0_ready",       64'(pready[0]), 64'(1));
      check("w0_pslverr",     64'(pslverr[0]), 64'(0));
      check("w0_not_yet",     reg_q0, 64'(0));
      check("w0_strb_early",  64'(strb0), 64'(0));
      psel[0] = 1'b0; penable = 1'b0;
      tick;
      check("w0_ready_drop",  64'(pready[0]), 64'(0));
      check("w0_strb",        64'(strb0), 64'h04);
      check("w0_regs",        reg_q0, 64'h0000_0000_00A5_0000);
      tick;
      check("w0_strb_clear",  64'(strb0), 64'(0));

      // ---------------- back-to-back writes 11@0, 22@1 ----------------
      psel[0] = 1'b1; penable = 1'b0; paddr = 3'd0; pwdata = 8'h11;
      tick;
      penable = 1'b1;
      tick;
      check("b2b_ready1", 64'(pready[0]), 64'(1));
      penable = 1'b0; paddr = 3'd1; pwdata = 8'h22;
      tick;
      check("b2b_gap",    64'(pready[0]), 64'(0));
      check("b2b_strb1",  64'(strb0), 64'h01);
      check("b2b_reg0",   64'(reg_q0[7:0]), 64'h11);
      penable = 1'b1;
      tick;
      check("b2b_ready2", 64'(pready[0]), 64'(1));
      psel[0] = 1'b0; penable = 1'b0;
      tick;
      check("b2b_strb2",  64'(strb0), 64'h02);
      check("b2b_regs",   reg_q0, 64'h0000_0000_00A5_2211);

      xfer(0, 1'b0, 3'd1, 8'h00, lat, rd, err, stray);
      check("r0_lat",   64'(lat), 64'(2));
      check("r0_data",  64'(rd), 64'h22);
      check("r0_stray", 64'(stray), 64'(0));
      tick;
      check("r0_after", 64'(prdata[0]), 64'(0));

      // ---------------- WAIT_STATES=3 ----------------
      xfer(1, 1'b1, 3'd2, 8'hA5, lat, rd, err, stray);
      check("w3_wr_lat", 64'(lat), 64'(5));
      tick;
      check("w3_regs",   reg_q1, 64'h0000_0000_00A5_0000);
      check("w3_strb",   64'(strb1), 64'h04);
      xfer(1, 1'b0, 3'd2, 8'h00, lat, rd, err, stray);
      check("w3_rd_lat", 64'(lat), 64'(5));
      check("w3_rdata",  64'(rd), 64'hA5);
      check("w3_stray",  64'(stray), 64'(0));
      tick;
      check("w3_after",  64'(prdata[1]), 64'(0));

      // ---------------- NUM_REGS=6, out-of-range index ----------------
      xfer(2, 1'b1, 3'd7, 8'h77, lat, rd, err, stray);
      check("oor_wr_lat", 64'(lat), 64'(4));
      check("oor_wr_err", 64'(err), 64'(EXP_ERR));
      tick;
      check("oor_regs",   64'(reg_q2), 64'h5A5A_5A5A_5A5A);
      check("oor_strb",   64'(strb2), 64'(0));
      xfer(2, 1'b0, 3'd7, 8'h00, lat, rd, err, stray);
      check("oor_rdata",  64'(rd), 64'(0));
      check("oor_rd_err", 64'(err), 64'(EXP_ERR));
      tick;
      xfer(2, 1'b1, 3'd5, 8'hC3, lat, rd, err, stray);
      check("top_wr_err", 64'(err), 64'(0));
      tick;
      check("top_regs",   64'(reg_q2), 64'hC35A_5A5A_5A5A);
      check("top_strb",   64'(strb2), 64'h20);
      xfer(2, 1'b0, 3'd6, 8'h00, lat, rd, err, stray);
      check("oor6_rdata", 64'(rd), 64'(0));
      check("oor6_err",   64'(err), 64'(EXP_ERR));
      tick;

      // ---------------- abort: psel drops during ACCESS ----------------
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'h99;
      tick;
      penable = 1'b1;
      tick;
      check("abort_in_access", 64'(pready[2]), 64'(0));
      psel[2] = 1'b0; penable = 1'b0;
      any_rdy = 1'b0; any_strb = '0;
      for (int i = 0; i < 5; i++) begin
         tick;
         any_rdy  |= pready[2];
         any_strb |= strb2;
      end
      check("abort_no_ready", 64'(any_rdy), 64'(0));
      check("abort_no_strb",  64'(any_strb), 64'(0));
      check("abort_regs",     64'(reg_q2), 64'hC35A_5A5A_5A5A);
      xfer(2, 1'b0, 3'd1, 8'h00, lat, rd, err, stray);
      check("abort_rd_lat",   64'(lat), 64'(4));
      check("abort_rdata",    64'(rd), 64'h5A);
      tick;

      // ---------------- reset pulse mid-ACCESS ----------------
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h42;
      tick;
      penable = 1'b1;
      tick;
      tick;
      reset_n = 1'b0;
      #2;
      check("rst_mid_pready", 64'(pready[2]), 64'(0));
      check("rst_mid_regs2",  64'(reg_q2), 64'h5A5A_5A5A_5A5A);
      check("rst_mid_regs0",  reg_q0, 64'(0));
      check("rst_mid_regs1",  reg_q1, 64'(0));
      reset_n = 1'b1;
      // Bus still shows psel/penable: no setup phase, so nothing may start.
      any_rdy = 1'b0; any_strb = '0;
      for (int i = 0; i < 5; i++) begin
         tick;
         any_rdy  |= pready[2];
         any_strb |= strb2;
      end
      check("rst_post_ready", 64'(any_rdy), 64'(0));
      check("rst_post_strb",  64'(any_strb), 64'(0));
      check("rst_post_regs",  64'(reg_q2), 64'h5A5A_5A5A_5A5A);
      psel[2] = 1'b0; penable = 1'b0;
      tick;
      xfer(2, 1'b1, 3'd0, 8'h42, lat, rd, err, stray);
      check("fresh_lat",  64'(lat), 64'(4));
      tick;
      check("fresh_regs", 64'(reg_q2), 64'h5A5A_5A5A_5A42);
      check("fresh_strb", 64'(strb2), 64'h01);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_apb_reg_slave
`default_nettype wire
